// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: packet-granular round-robin arbiter in front of the LCD_Controller Avalon-MM port,
// with a watchdog that drops a stalled slave or a requester that goes silent mid-packet.
module lcd_bus_arbiter #(
  parameter int N_REQ = 2,
  parameter int MAX_WAIT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*9-1:0] req_instr,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               timeout_err,
  output logic               address,
  output logic               chipselect,
  output logic               byteenable,
  output logic               read,
  output logic               write,
  output logic [7:0]         writedata,
  input  logic               waitrequest,
  input  logic [7:0]         readdata,
  input  logic [1:0]         response
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_WAIT) + 1;
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] owner, rr_ptr, pick;
  logic [CW-1:0] wait_cnt;
  logic [8:0] instr;
  logic found, valid, last, active, accept, abort;
  logic unused_bits;
  int idx;
  assign unused_bits = ^{readdata, response};
  assign instr = req_instr[owner*9 +: 9];
  assign valid = req_valid[owner];
  assign last = req_last[owner];
  // a dropped valid in WRITE is treated like HOLD so a stale beat is never written
  assign active = state == WRITE && valid;
  assign accept = active && !waitrequest;
  assign abort = state != IDLE && !accept && wait_cnt >= CW'(MAX_WAIT - 1);
  assign write = active;
  assign chipselect = active;
  assign address = active & instr[8];
  assign writedata = active ? instr[7:0] : 8'h00;
  assign req_ready = accept ? grant : '0;
  assign byteenable = 1'b1;
  assign read = 1'b0;
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req_valid[PW'(idx)]) begin
        pick = PW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = (abort || (accept && last)) ? IDLE :
              (state == IDLE && found)    ? WRITE :
              (state == WRITE && !valid)  ? HOLD :
              (state == HOLD && valid)    ? WRITE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      rr_ptr <= PW'(N_REQ - 1);
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      timeout_err <= abort;
      wait_cnt <= (state_n != state || accept || state == IDLE) ? '0 :
                  (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
      if (abort || (accept && last)) begin
        grant <= '0;
        rr_ptr <= owner;
      end else if (state == IDLE && found) begin
        owner <= pick;
        grant <= '0;
        grant[pick] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed scenario tests for lcd_bus_arbiter with two requesters and an
// eight-cycle watchdog; each task checks its own cycle-by-cycle expectations.
module tb_lcd_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_last, req_ready, grant;
  logic [17:0] req_instr;
  logic timeout_err, address, chipselect, byteenable, read, write, waitrequest;
  logic [7:0] writedata;
  logic [7:0] readdata = 8'h00;
  logic [1:0] response = 2'b00;
  int tests = 0;
  int fails = 0;

  lcd_bus_arbiter #(.N_REQ(2), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_instr(req_instr),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .timeout_err(timeout_err),
    .address(address), .chipselect(chipselect), .byteenable(byteenable), .read(read),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .response(response)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int i, input logic [8:0] v);
    req_instr[i*9 +: 9] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_instr = '0;
    waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    do_reset();
    @(negedge clk);
    obs = {grant, req_ready, timeout_err, write, chipselect, address, writedata, byteenable, read};
    tests++;
    if (obs !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got %h want %h", obs, {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    end
    step();
  endtask

  task automatic test_single();
    logic [8:0] v [3] = '{9'h001, 9'h043, 9'h16D};
    logic [13:0] obs, exp;
    do_reset();
    req_valid = 2'b01;
    set_instr(0, v[0]);
    @(negedge clk);
    tests++;
    if ({grant, write} !== 3'b000) begin
      fails++;
      $display("FAIL single_c0: got grant/write %b want 000", {grant, write});
    end
    step();
    for (int k = 0; k < 3; k++) begin
      set_instr(0, v[k]);
      req_last[0] = (k == 2);
      @(negedge clk);
      obs = {write, chipselect, address, writedata, req_ready, grant};
      exp = {1'b1, 1'b1, v[k][8], v[k][7:0], 2'b01, 2'b01};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL single_beat%0d: got %h want %h", k, obs, exp);
      end
      step();
    end
    req_valid = 2'b00;
    @(negedge clk);
    tests++;
    if ({grant, write, req_ready} !== 5'b00000) begin
      fails++;
      $display("FAIL single_end: got grant/write/ready %b want 00000", {grant, write, req_ready});
    end
    step();
  endtask

  task automatic test_fairness();
    logic [8:0] d [2][2] = '{'{9'h0A0, 9'h1A1}, '{9'h0B0, 9'h1B1}};
    logic [1:0] eg [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    logic [7:0] ew [12] = '{8'h00, 8'hA0, 8'hA1, 8'h00, 8'hB0, 8'hB1, 8'h00, 8'hA0, 8'hA1, 8'h00, 8'hB0, 8'hB1};
    int b [2] = '{0, 0};
    logic [1:0] rdy;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
        set_instr(i, d[i][b[i]]);
        req_last[i] = (b[i] == 1);
      end
      @(negedge clk);
      tests++;
      if ({grant, writedata} !== {eg[c], ew[c]}) begin
        fails++;
        $display("FAIL fair_c%0d: got grant %b data %h want grant %b data %h", c, grant, writedata, eg[c], ew[c]);
      end
      rdy = req_ready;
      step();
      for (int i = 0; i < 2; i++) if (rdy[i]) b[i] ^= 1;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_stall();
    logic [8:0] v [3] = '{9'h041, 9'h042, 9'h143};
    logic [7:0] ew [10] = '{8'h00, 8'h41, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h43, 8'h00};
    logic er [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int b = 0;
    logic r;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid[0] = (b < 3);
      if (b < 3) begin
        set_instr(0, v[b]);
        req_last[0] = (b == 2);
      end
      waitrequest = (c >= 2 && c <= 6);
      @(negedge clk);
      tests++;
      if ({write, writedata, req_ready[0]} !== {(c >= 1 && c <= 8), ew[c], er[c]}) begin
        fails++;
        $display("FAIL stall_c%0d: got write %b data %h ready %b want %b %h %b",
                 c, write, writedata, req_ready[0], (c >= 1 && c <= 8), ew[c], er[c]);
      end
      r = req_ready[0];
      step();
      if (r) b++;
    end
    waitrequest = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_hold();
    logic [1:0] eg [10] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [7:0] ew [10] = '{8'h00, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC1, 8'h00, 8'hD0};
    logic [1:0] er [10] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
    logic ewr;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid[1] = (c <= 1) || (c == 6) || (c == 7);
      set_instr(1, (c < 6) ? 9'h0C0 : 9'h1C1);
      req_last[1] = (c >= 6);
      req_valid[0] = (c >= 2);
      set_instr(0, 9'h0D0);
      req_last[0] = 1'b1;
      ewr = (c == 1) || (c == 7) || (c == 9);
      @(negedge clk);
      tests++;
      if ({grant, write, writedata, req_ready} !== {eg[c], ewr, ew[c], er[c]}) begin
        fails++;
        $display("FAIL hold_c%0d: got grant %b write %b data %h ready %b want %b %b %h %b",
                 c, grant, write, writedata, req_ready, eg[c], ewr, ew[c], er[c]);
      end
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_watchdog();
    logic [1:0] eg;
    logic ew, et;
    logic [1:0] er;
    do_reset();
    req_valid = 2'b11;
    set_instr(0, 9'h055);
    set_instr(1, 9'h166);
    req_last = 2'b10;
    for (int c = 0; c <= 10; c++) begin
      waitrequest = (c < 10);
      eg = (c >= 1 && c <= 8) ? 2'b01 : (c == 10) ? 2'b10 : 2'b00;
      ew = (c >= 1 && c <= 8) || (c == 10);
      et = (c == 9);
      er = (c == 10) ? 2'b10 : 2'b00;
      @(negedge clk);
      tests++;
      if ({grant, write, req_ready, timeout_err} !== {eg, ew, er, et}) begin
        fails++;
        $display("FAIL watchdog_c%0d: got grant %b write %b ready %b timeout %b want %b %b %b %b",
                 c, grant, write, req_ready, timeout_err, eg, ew, er, et);
      end
      step();
    end
    req_valid = 2'b00;
    waitrequest = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] v [4] = '{9'h011, 9'h012, 9'h013, 9'h114};
    logic [17:0] obs;
    do_reset();
    req_valid = 2'b01;
    set_instr(0, v[0]);
    step();
    step();
    set_instr(0, v[1]);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({write, writedata} !== {1'b1, 8'h12}) begin
      fails++;
      $display("FAIL midreset_beat2: got write %b data %h want 1 12", write, writedata);
    end
    step();
    @(negedge clk);
    obs = {grant, req_ready, timeout_err, write, chipselect, address, writedata, byteenable, read};
    tests++;
    if (obs !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midreset_outputs: got %h want %h", obs, {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    end
    step();
    reset = 1'b0;
    req_valid = 2'b11;
    set_instr(0, v[0]);
    set_instr(1, 9'h1EE);
    req_last = 2'b10;
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL midreset_idle: got grant %b want 00", grant);
    end
    step();
    @(negedge clk);
    tests++;
    if ({grant, writedata} !== {2'b01, 8'h11}) begin
      fails++;
      $display("FAIL midreset_regrant: got grant %b data %h want 01 11", grant, writedata);
    end
    step();
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_hold();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
